// File: rtl/pkt_rx_checker.sv
// Egress packet-bus terminator: checks framing and end-of-packet status, emits a one-cycle descriptor and keeps counters.
// Define PKT_RX_LEN_CHECK_EN to flag packets whose received byte count differs from the metadata length.
module pkt_rx_checker #(
   parameter int CNT_W      = 32,
   parameter int META_WORDS = 2,
   parameter int META_BYTES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [133:0]     pktin_data,
   input  logic             pktin_data_wr,
   input  logic             pktin_valid,
   input  logic             pktin_valid_wr,
   input  logic [47:0]      local_mac_addr,
   output logic             desc_valid,
   output logic [5:0]       desc_inport,
   output logic [7:0]       desc_smid,
   output logic [11:0]      desc_len,
   output logic [47:0]      desc_dmac,
   output logic [47:0]      desc_smac,
   output logic             desc_vlan,
   output logic [2:0]       desc_pcp,
   output logic [11:0]      desc_vid,
   output logic             desc_local,
   output logic             desc_err,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] byte_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_META, S_HDR, S_BODY} state_t;

   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_BODY = 2'b11;
   localparam logic [1:0] T_TAIL = 2'b10;

   state_t           state_q, state_d;
   logic [5:0]       inport_q, inport_d;
   logic [7:0]       smid_q, smid_d;
   logic [11:0]      len_q, len_d;
   logic [47:0]      dmac_q, dmac_d;
   logic [47:0]      smac_q, smac_d;
   logic             vlan_q, vlan_d;
   logic [2:0]       pcp_q, pcp_d;
   logic [11:0]      vid_q, vid_d;
   logic [CNT_W-1:0] bytes_q, bytes_d;

   logic             desc_valid_q, desc_valid_d;
   logic [5:0]       desc_inport_q, desc_inport_d;
   logic [7:0]       desc_smid_q, desc_smid_d;
   logic [11:0]      desc_len_q, desc_len_d;
   logic [47:0]      desc_dmac_q, desc_dmac_d;
   logic [47:0]      desc_smac_q, desc_smac_d;
   logic             desc_vlan_q, desc_vlan_d;
   logic [2:0]       desc_pcp_q, desc_pcp_d;
   logic [11:0]      desc_vid_q, desc_vid_d;
   logic             desc_local_q, desc_local_d;
   logic             desc_err_q, desc_err_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

   logic             is_head, is_body, is_tail;
   logic             status_err, bad_word, end_pkt, pkt_bad, start_pkt;
   logic             hdr_vlan;
   logic [CNT_W-1:0] bytes_now;
   logic             unused_dei;

   assign is_head    = pktin_data_wr && (pktin_data[133:132] == T_HEAD);
   assign is_body    = pktin_data_wr && (pktin_data[133:132] == T_BODY);
   assign is_tail    = pktin_data_wr && (pktin_data[133:132] == T_TAIL);
   assign status_err = pktin_valid_wr && !is_tail;
   assign hdr_vlan   = (pktin_data[31:16] == 16'h8100);
   assign unused_dei = pktin_data[12];

   always_comb begin
      state_d       = state_q;
      inport_d      = inport_q;
      smid_d        = smid_q;
      len_d         = len_q;
      dmac_d        = dmac_q;
      smac_d        = smac_q;
      vlan_d        = vlan_q;
      pcp_d         = pcp_q;
      vid_d         = vid_q;
      desc_valid_d  = 1'b0;
      desc_inport_d = desc_inport_q;
      desc_smid_d   = desc_smid_q;
      desc_len_d    = desc_len_q;
      desc_dmac_d   = desc_dmac_q;
      desc_smac_d   = desc_smac_q;
      desc_vlan_d   = desc_vlan_q;
      desc_pcp_d    = desc_pcp_q;
      desc_vid_d    = desc_vid_q;
      desc_local_d  = desc_local_q;
      desc_err_d    = desc_err_q;
      pkt_cnt_d     = pkt_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      bytes_now     = bytes_q;
      bad_word      = 1'b0;
      end_pkt       = 1'b0;
      pkt_bad       = 1'b0;
      start_pkt     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (is_head)             start_pkt = 1'b1;
            else if (pktin_data_wr)  bad_word  = 1'b1;
         end
         S_META: begin
            if (is_head) begin
               end_pkt = 1'b1; pkt_bad = 1'b1; start_pkt = 1'b1;
            end else if (is_body) begin
               state_d = S_HDR;
            end else if (is_tail) begin
               end_pkt = 1'b1; pkt_bad = 1'b1;
            end else if (pktin_data_wr) begin
               bad_word = 1'b1;
            end
         end
         default: begin
            if (is_head) begin
               end_pkt = 1'b1; pkt_bad = 1'b1; start_pkt = 1'b1;
            end else if (is_body || is_tail) begin
               bytes_now = bytes_q + CNT_W'(16) - (is_tail ? CNT_W'(pktin_data[131:128]) : '0);
               state_d   = S_BODY;
               if (state_q == S_HDR) begin
                  dmac_d = pktin_data[127:80];
                  smac_d = pktin_data[79:32];
                  vlan_d = hdr_vlan;
                  pcp_d  = hdr_vlan ? pktin_data[15:13] : 3'd0;
                  vid_d  = hdr_vlan ? pktin_data[11:0] : 12'd0;
               end
               if (is_tail) begin
                  end_pkt = 1'b1;
                  // A tail without its status strobe is treated as a discard.
                  pkt_bad = !(pktin_valid_wr && pktin_valid);
`ifdef PKT_RX_LEN_CHECK_EN
                  if (bytes_now != CNT_W'(len_q)) pkt_bad = 1'b1;
`endif
               end
            end else if (pktin_data_wr) begin
               bad_word = 1'b1;
            end
         end
      endcase

      bytes_d = bytes_now;

      // Descriptor takes the old packet's fields before a same-cycle head overwrites them.
      if (end_pkt) begin
         desc_valid_d  = 1'b1;
         desc_inport_d = inport_q;
         desc_smid_d   = smid_q;
         desc_len_d    = len_q;
         desc_dmac_d   = dmac_d;
         desc_smac_d   = smac_d;
         desc_vlan_d   = vlan_d;
         desc_pcp_d    = pcp_d;
         desc_vid_d    = vid_d;
         desc_local_d  = (dmac_d == local_mac_addr);
         desc_err_d    = pkt_bad;
         state_d       = S_IDLE;
         if (!pkt_bad) begin
            pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
            byte_cnt_d = byte_cnt_q + bytes_now;
         end
      end

      err_cnt_d = err_cnt_q + CNT_W'(bad_word) + CNT_W'(status_err) + CNT_W'(end_pkt && pkt_bad);

      if (start_pkt) begin
         inport_d = pktin_data[125:120];
         len_d    = pktin_data[107:96];
         smid_d   = pktin_data[95:88];
         dmac_d   = '0;
         smac_d   = '0;
         vlan_d   = 1'b0;
         pcp_d    = '0;
         vid_d    = '0;
         bytes_d  = CNT_W'(META_BYTES);
         state_d  = (META_WORDS > 1) ? S_META : S_HDR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         inport_q      <= '0;
         smid_q        <= '0;
         len_q         <= '0;
         dmac_q        <= '0;
         smac_q        <= '0;
         vlan_q        <= 1'b0;
         pcp_q         <= '0;
         vid_q         <= '0;
         bytes_q       <= '0;
         desc_valid_q  <= 1'b0;
         desc_inport_q <= '0;
         desc_smid_q   <= '0;
         desc_len_q    <= '0;
         desc_dmac_q   <= '0;
         desc_smac_q   <= '0;
         desc_vlan_q   <= 1'b0;
         desc_pcp_q    <= '0;
         desc_vid_q    <= '0;
         desc_local_q  <= 1'b0;
         desc_err_q    <= 1'b0;
         pkt_cnt_q     <= '0;
         err_cnt_q     <= '0;
         byte_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         inport_q      <= inport_d;
         smid_q        <= smid_d;
         len_q         <= len_d;
         dmac_q        <= dmac_d;
         smac_q        <= smac_d;
         vlan_q        <= vlan_d;
         pcp_q         <= pcp_d;
         vid_q         <= vid_d;
         bytes_q       <= bytes_d;
         desc_valid_q  <= desc_valid_d;
         desc_inport_q <= desc_inport_d;
         desc_smid_q   <= desc_smid_d;
         desc_len_q    <= desc_len_d;
         desc_dmac_q   <= desc_dmac_d;
         desc_smac_q   <= desc_smac_d;
         desc_vlan_q   <= desc_vlan_d;
         desc_pcp_q    <= desc_pcp_d;
         desc_vid_q    <= desc_vid_d;
         desc_local_q  <= desc_local_d;
         desc_err_q    <= desc_err_d;
         pkt_cnt_q     <= pkt_cnt_d;
         err_cnt_q     <= err_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
      end
   end

   assign desc_valid  = desc_valid_q;
   assign desc_inport = desc_inport_q;
   assign desc_smid   = desc_smid_q;
   assign desc_len    = desc_len_q;
   assign desc_dmac   = desc_dmac_q;
   assign desc_smac   = desc_smac_q;
   assign desc_vlan   = desc_vlan_q;
   assign desc_pcp    = desc_pcp_q;
   assign desc_vid    = desc_vid_q;
   assign desc_local  = desc_local_q;
   assign desc_err    = desc_err_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign err_cnt     = err_cnt_q;
   assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Directed bench for pkt_rx_checker: a vector table for framing/status corner cases plus hand-written packet sequences.
module tb_pkt_rx_checker;

   localparam logic [47:0]  MAC   = 48'h0023cd76631a;
   localparam logic [127:0] HDR   = {MAC, MAC, 16'h8100, 16'h9280};
   localparam logic [127:0] META1 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
   localparam logic [127:0] BODYP = 128'hdead_beef_cafe_f00d_5a5a_a5a5_1234_8765;

   logic         clk = 1'b0;
   logic         rst;
   logic [133:0] pktin_data;
   logic         pktin_data_wr, pktin_valid, pktin_valid_wr;
   logic [47:0]  local_mac_addr;
   logic         desc_valid, desc_vlan, desc_local, desc_err;
   logic [5:0]   desc_inport;
   logic [7:0]   desc_smid;
   logic [11:0]  desc_len, desc_vid;
   logic [47:0]  desc_dmac, desc_smac;
   logic [2:0]   desc_pcp;
   logic [31:0]  pkt_cnt, err_cnt, byte_cnt;

   pkt_rx_checker dut (
      .clk(clk), .rst(rst),
      .pktin_data(pktin_data), .pktin_data_wr(pktin_data_wr),
      .pktin_valid(pktin_valid), .pktin_valid_wr(pktin_valid_wr),
      .local_mac_addr(local_mac_addr),
      .desc_valid(desc_valid), .desc_inport(desc_inport), .desc_smid(desc_smid),
      .desc_len(desc_len), .desc_dmac(desc_dmac), .desc_smac(desc_smac),
      .desc_vlan(desc_vlan), .desc_pcp(desc_pcp), .desc_vid(desc_vid),
      .desc_local(desc_local), .desc_err(desc_err),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .byte_cnt(byte_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_fail = 0;
   int dv_pulses = 0;
   int p0;

   always @(posedge clk) if (desc_valid === 1'b1) dv_pulses++;

   typedef struct {
      logic [133:0] d;
      logic         wr, vwr, v;
      logic         dv, err;
      logic [31:0]  pkt, errc, bytes;
   } vec_t;

   vec_t vt[$];

   function automatic logic [133:0] w_meta0(logic [5:0] ip, logic [7:0] sm, logic [11:0] len);
      return {2'b01, 4'h0, 2'b00, ip, 12'h000, len, sm, 88'h0};
   endfunction
   function automatic logic [133:0] w_body(logic [127:0] p);
      return {2'b11, 4'h0, p};
   endfunction
   function automatic logic [133:0] w_tail(logic [3:0] inv, logic [127:0] p);
      return {2'b10, inv, p};
   endfunction
   function automatic vec_t mkv(logic [133:0] d, logic wr, logic vwr, logic v, logic dv, logic err,
                                logic [31:0] pkt, logic [31:0] errc, logic [31:0] bytes);
      vec_t r;
      r.d = d; r.wr = wr; r.vwr = vwr; r.v = v; r.dv = dv; r.err = err;
      r.pkt = pkt; r.errc = errc; r.bytes = bytes;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [133:0] d, input logic vwr, input logic v);
      pktin_data = d; pktin_data_wr = 1'b1; pktin_valid_wr = vwr; pktin_valid = v;
      @(posedge clk); #1;
      pktin_data_wr = 1'b0; pktin_valid_wr = 1'b0; pktin_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Everything after the head of the standard 7-word, 110-byte packet.
   task automatic send_rest(input logic v);
      send(w_body(META1), 1'b0, 1'b0);
      send(w_body(HDR), 1'b0, 1'b0);
      repeat (3) send(w_body(BODYP), 1'b0, 1'b0);
      send(w_tail(4'd2, BODYP), 1'b1, v);
   endtask

   task automatic send_pkt(input logic [5:0] ip, input logic [7:0] sm, input logic [11:0] len, input logic v);
      send(w_meta0(ip, sm, len), 1'b0, 1'b0);
      send_rest(v);
   endtask

   initial begin
      rst = 1'b1; pktin_data = '0; pktin_data_wr = 1'b0; pktin_valid = 1'b0; pktin_valid_wr = 1'b0;
      local_mac_addr = MAC;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset desc_valid", desc_valid, 0);
      chk("reset desc_err",   desc_err, 0);
      chk("reset desc_dmac",  desc_dmac, 0);
      chk("reset desc_len",   desc_len, 0);
      chk("reset desc_local", desc_local, 0);
      chk("reset pkt_cnt",    pkt_cnt, 0);
      chk("reset err_cnt",    err_cnt, 0);
      chk("reset byte_cnt",   byte_cnt, 0);

      //                  data                                  wr vwr v   dv err pkt errc bytes
      vt.push_back(mkv(w_body(BODYP),                         1, 0, 0,  0, 0,  0, 1,   0));
      vt.push_back(mkv('0,                                    0, 1, 1,  0, 0,  0, 2,   0));
      vt.push_back(mkv('0,                                    0, 0, 0,  0, 0,  0, 2,   0));
      vt.push_back(mkv(w_meta0(6'd1, 8'd1, 12'h010),          1, 0, 0,  0, 0,  0, 2,   0));
      vt.push_back(mkv(w_tail(4'd2, BODYP),                   1, 1, 1,  1, 1,  0, 3,   0));
      vt.push_back(mkv(w_meta0(6'd2, 8'd2, 12'd48),           1, 0, 0,  0, 0,  0, 3,   0));
      vt.push_back(mkv(w_body(META1),                         1, 0, 0,  0, 0,  0, 3,   0));
      vt.push_back(mkv(w_tail(4'd0, HDR),                     1, 1, 1,  1, 0,  1, 3,  48));
      vt.push_back(mkv(w_meta0(6'd3, 8'd3, 12'd78),           1, 0, 0,  0, 0,  1, 3,  48));
      vt.push_back(mkv(w_body(META1),                         1, 0, 0,  0, 0,  1, 3,  48));
      vt.push_back(mkv(w_body(HDR),                           1, 0, 0,  0, 0,  1, 3,  48));
      vt.push_back(mkv(w_body(BODYP),                         1, 0, 0,  0, 0,  1, 3,  48));
      vt.push_back(mkv(w_tail(4'd2, BODYP),                   1, 0, 0,  1, 1,  1, 4,  48));
      vt.push_back(mkv(w_meta0(6'd4, 8'd4, 12'd78),           1, 0, 0,  0, 0,  1, 4,  48));
      vt.push_back(mkv(w_body(META1),                         1, 0, 0,  0, 0,  1, 4,  48));
      vt.push_back(mkv(w_body(HDR),                           1, 1, 1,  0, 0,  1, 5,  48));
      vt.push_back(mkv(w_body(BODYP),                         1, 0, 0,  0, 0,  1, 5,  48));
      vt.push_back(mkv(w_tail(4'd2, BODYP),                   1, 1, 1,  1, 0,  2, 5, 126));
      vt.push_back(mkv(w_meta0(6'd5, 8'd5, 12'd62),           1, 0, 0,  0, 0,  2, 5, 126));
      vt.push_back(mkv(w_body(META1),                         1, 0, 0,  0, 0,  2, 5, 126));
      vt.push_back(mkv(w_body(HDR),                           1, 0, 0,  0, 0,  2, 5, 126));
      vt.push_back(mkv(w_meta0(6'd6, 8'd6, 12'd62),           1, 1, 1,  1, 1,  2, 7, 126));
      vt.push_back(mkv(w_body(META1),                         1, 0, 0,  0, 0,  2, 7, 126));
      vt.push_back(mkv(w_body(HDR),                           1, 0, 0,  0, 0,  2, 7, 126));
      vt.push_back(mkv(w_tail(4'd2, BODYP),                   1, 1, 1,  1, 0,  3, 7, 188));

      for (int i = 0; i < vt.size(); i++) begin
         pktin_data = vt[i].d; pktin_data_wr = vt[i].wr;
         pktin_valid_wr = vt[i].vwr; pktin_valid = vt[i].v;
         @(posedge clk); #1;
         pktin_data_wr = 1'b0; pktin_valid_wr = 1'b0; pktin_valid = 1'b0;
         chk($sformatf("vec%0d desc_valid", i), desc_valid, vt[i].dv);
         if (vt[i].dv) chk($sformatf("vec%0d desc_err", i), desc_err, vt[i].err);
         chk($sformatf("vec%0d pkt_cnt", i),  pkt_cnt,  vt[i].pkt);
         chk($sformatf("vec%0d err_cnt", i),  err_cnt,  vt[i].errc);
         chk($sformatf("vec%0d byte_cnt", i), byte_cnt, vt[i].bytes);
      end

      // Nominal packet with full descriptor check.
      do_reset();
      send_pkt(6'h2a, 8'h5c, 12'h06e, 1'b1);
      chk("nom desc_valid",  desc_valid, 1);
      chk("nom desc_inport", desc_inport, 6'h2a);
      chk("nom desc_smid",   desc_smid, 8'h5c);
      chk("nom desc_len",    desc_len, 12'h06e);
      chk("nom desc_dmac",   desc_dmac, MAC);
      chk("nom desc_smac",   desc_smac, MAC);
      chk("nom desc_vlan",   desc_vlan, 1);
      chk("nom desc_pcp",    desc_pcp, 4);
      chk("nom desc_vid",    desc_vid, 12'h280);
      chk("nom desc_local",  desc_local, 1);
      chk("nom desc_err",    desc_err, 0);
      chk("nom pkt_cnt",     pkt_cnt, 1);
      chk("nom byte_cnt",    byte_cnt, 110);
      chk("nom err_cnt",     err_cnt, 0);
      idle(1);
      chk("nom desc_valid drop", desc_valid, 0);

      // 50 packets with 2-cycle gaps, then 50 back to back.
      do_reset();
      p0 = dv_pulses;
      for (int i = 0; i < 50; i++) begin
         send_pkt(6'd0, 8'd0, 12'h06e, 1'b1);
         idle(2);
      end
      for (int i = 0; i < 50; i++) send_pkt(6'd0, 8'd0, 12'h06e, 1'b1);
      idle(2);
      chk("bulk pkt_cnt",  pkt_cnt, 100);
      chk("bulk err_cnt",  err_cnt, 0);
      chk("bulk byte_cnt", byte_cnt, 11000);
      chk("bulk pulses",   dv_pulses - p0, 100);

      // Discard status at tail.
      send_pkt(6'd0, 8'd0, 12'h06e, 1'b0);
      chk("discard desc_valid", desc_valid, 1);
      chk("discard desc_err",   desc_err, 1);
      chk("discard err_cnt",    err_cnt, 1);
      chk("discard pkt_cnt",    pkt_cnt, 100);
      chk("discard byte_cnt",   byte_cnt, 11000);
      idle(1);

      // Head injected as word 4 aborts the packet and starts a good one.
      do_reset();
      send(w_meta0(6'd7, 8'd7, 12'h06e), 1'b0, 1'b0);
      send(w_body(META1), 1'b0, 1'b0);
      send(w_body(HDR), 1'b0, 1'b0);
      send(w_body(BODYP), 1'b0, 1'b0);
      send(w_meta0(6'd9, 8'd9, 12'h06e), 1'b0, 1'b0);
      chk("abort desc_valid", desc_valid, 1);
      chk("abort desc_err",   desc_err, 1);
      chk("abort desc_inport", desc_inport, 7);
      chk("abort err_cnt",    err_cnt, 1);
      send_rest(1'b1);
      chk("after-abort desc_valid",  desc_valid, 1);
      chk("after-abort desc_err",    desc_err, 0);
      chk("after-abort desc_inport", desc_inport, 9);
      chk("after-abort pkt_cnt",     pkt_cnt, 1);
      chk("after-abort err_cnt",     err_cnt, 1);
      chk("after-abort byte_cnt",    byte_cnt, 110);
      idle(1);

      // Metadata length 0x70 against a 110-byte packet.
      do_reset();
      send_pkt(6'd0, 8'd0, 12'h070, 1'b1);
      chk("lenchk desc_valid", desc_valid, 1);
`ifdef PKT_RX_LEN_CHECK_EN
      chk("lenchk desc_err", desc_err, 1);
      chk("lenchk err_cnt",  err_cnt, 1);
      chk("lenchk pkt_cnt",  pkt_cnt, 0);
`else
      chk("lenchk desc_err", desc_err, 0);
      chk("lenchk err_cnt",  err_cnt, 0);
      chk("lenchk pkt_cnt",  pkt_cnt, 1);
`endif
      idle(1);

      // Reset during word 3 abandons the packet silently.
      send(w_meta0(6'd0, 8'd0, 12'h06e), 1'b0, 1'b0);
      send(w_body(META1), 1'b0, 1'b0);
      pktin_data = w_body(HDR); pktin_data_wr = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; pktin_data_wr = 1'b0;
      chk("rst-mid pkt_cnt",    pkt_cnt, 0);
      chk("rst-mid err_cnt",    err_cnt, 0);
      chk("rst-mid byte_cnt",   byte_cnt, 0);
      chk("rst-mid desc_valid", desc_valid, 0);
      p0 = dv_pulses;
      send_pkt(6'd0, 8'd0, 12'h06e, 1'b1);
      idle(2);
      chk("rst-mid pulses",        dv_pulses - p0, 1);
      chk("rst-mid final pkt_cnt", pkt_cnt, 1);
      chk("rst-mid final err_cnt", err_cnt, 0);
      chk("rst-mid final bytes",   byte_cnt, 110);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/pkt_rx_checker.md
Name: pkt_rx_checker

Overview:
- Sink-side terminator for the 134-bit packet bus that the UM pipeline emits (pktout side); mirror of the stimulus generator that feeds pktin.
- Consumes metadata + frame words, validates framing, length and end-of-packet valid, and extracts header fields into a one-cycle descriptor.
- Keeps packet/error counters for the bench and for debug registers.
- Used in simulation and synthesised as a loopback monitor at the esw egress.

Parameters:
- CNT_W, 32, width of pkt_cnt / err_cnt / byte counters
- META_WORDS, 2, metadata words preceding frame data (fixed 2; legal values 1..2)
- META_BYTES, 32, bytes of metadata counted in the length field

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- pktin_data  in  134  [133:132] 01=head, 11=body, 10=tail; [131:128] invalid bytes in tail; [127:0] data
- pktin_data_wr  in  1  word strobe
- pktin_valid  in  1  1=packet good, 0=discard; sampled with pktin_valid_wr
- pktin_valid_wr  in  1  end-of-packet status strobe
- local_mac_addr  in  48  compared with DMAC
- desc_valid  out  1  one-cycle descriptor strobe
- desc_inport  out  6  meta0[125:120]
- desc_smid  out  8  meta0[95:88]
- desc_len  out  12  meta0[107:96]
- desc_dmac  out  48  frame word0[127:80]
- desc_smac  out  48  frame word0[79:32]
- desc_vlan  out  1  TPID (word0[31:16]) == 16'h8100
- desc_pcp  out  3  word0[15:13] if desc_vlan, else 0
- desc_vid  out  12  word0[11:0] if desc_vlan, else 0
- desc_local  out  1  desc_dmac == local_mac_addr
- desc_err  out  1  packet failed a check (descriptor still issued)
- pkt_cnt  out  CNT_W  good packets
- err_cnt  out  CNT_W  framing/length/valid errors
- byte_cnt  out  CNT_W  accumulated bytes of good packets, metadata included

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, FSM to IDLE. Reset mid-packet abandons the packet with no descriptor and no counter change.
- Input is sampled only when pktin_data_wr=1. Idle gaps of any length are legal.
- FSM states:
  - IDLE: head word (01) latches inport/smid/len and goes to META. Any other word: err_cnt+1, stay IDLE.
  - META: a body word completes metadata. Goes to HDR after META_WORDS-1 body words.
  - HDR: first frame word latches DMAC/SMAC/TPID/PCP/VID, then goes to BODY. A tail here is legal (1-word frame) and ends the packet.
  - BODY: body words accumulate; the tail word ends the packet and returns to IDLE.
- Byte count: words×16 − tail[131:128], counted over all words including metadata.
- Tail arriving in META: short packet. desc_err=1, descriptor issued, back to IDLE.
- Head arriving mid-packet: the current packet is aborted (descriptor issued, desc_err=1, err_cnt+1). The new head is processed in the same cycle.
- End-of-packet status:
  - pktin_valid_wr must coincide with the tail word.
  - pktin_valid=0 at tail gives desc_err=1.
  - pktin_valid_wr outside a tail: err_cnt+1 and ignored.
  - Tail without pktin_valid_wr counts as valid=0.
- Latency: descriptor fields and desc_valid are registered, so desc_valid rises the cycle after the tail is sampled. Held for exactly 1 cycle.
- Counter update on that same cycle:
  - Good packet: pkt_cnt+1 and byte_cnt += bytes.
  - Errored packet: err_cnt+1 and nothing else.
  - Simultaneous framing error and descriptor error: err_cnt+2.
- Counters wrap modulo 2^CNT_W; no saturation.
- Back-to-back packets with zero gap (tail then head next cycle) are accepted with no lost words.

Optional Feature:
- Macro: PKT_RX_LEN_CHECK_EN.
- Defined: at tail, compare computed bytes with desc_len. On mismatch set desc_err=1 and count the packet as an error, not in pkt_cnt.
- Undefined: desc_len is passed through unchecked. No comparator logic is built.

Test Plan:
- Nominal packet: inport 0, smid 0, len 0x6e, DMAC=SMAC=local 0023cd76631a, TPID 8100, TCI 0x9280, 7 words with tail invalid=2 and valid=1. Required: desc_valid 1 cycle after tail; pcp=4, vid=0x280, vlan=1, local=1, err=0; pkt_cnt=1, byte_cnt=110.
- 50 such packets with 2-cycle gaps, then 50 with 0 gap. Required: pkt_cnt=100, err_cnt=0, byte_cnt=11000, exactly 100 desc_valid pulses.
- Same packet with pktin_valid=0 at tail. Required: desc_err=1, err_cnt=1, pkt_cnt unchanged.
- Head injected at word 4 of a packet, then a full good packet. Required: one errored descriptor, then a good one; err_cnt=1, pkt_cnt=1.
- Length check: with PKT_RX_LEN_CHECK_EN, meta len=0x70 on the 110-byte packet gives desc_err=1 and err_cnt=1. Without the macro, the same packet is good and pkt_cnt=1.
- Reset: rst pulsed for 1 cycle during word 3, then a good packet. Required: all counters 0 after reset, only 1 descriptor, pkt_cnt=1.
